// File: rtl/mips_pkg.sv
// Shared types and sizing for the instruction-memory loader.
// The loader FSM state and frame geometry live here so the top and packer agree.
package mips_pkg;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LEN_W      = HDR_BYTES * 8;
  localparam int unsigned LANE_W     = $clog2(WORD_BYTES);
  localparam int unsigned WORD_W     = WORD_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } ld_state_e;

  // States in which the loader is willing to take a byte from the stream.
  function automatic logic is_load_state(input ld_state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes big-endian into 32-bit words; word_valid pulses for
// one cycle after the fourth lane is accepted and word holds until the next.
module imem_word_packer
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                accept,
  input  logic                clear,
  input  logic [7:0]          byte_in,
  output logic [LANE_W-1:0]   lane,
  output logic                word_valid,
  output logic [WORD_W-1:0]   word
);

  localparam int unsigned SR_W = WORD_W - 8;

  logic [SR_W-1:0]   sr_q, sr_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              word_valid_q, word_valid_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q         <= '0;
      lane_q       <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
    end else begin
      sr_q         <= sr_d;
      lane_q       <= lane_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
    end
  end

  // word_q only loads on the last lane so it stays stable between writes.
  always_comb begin
    sr_d         = sr_q;
    lane_d       = lane_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    if (clear) begin
      sr_d   = '0;
      lane_d = '0;
    end else if (accept) begin
      sr_d   = {sr_q[SR_W-9:0], byte_in};
      lane_d = lane_q + LANE_W'(1);
      if (lane_q == LANE_W'(WORD_BYTES - 1)) begin
        word_d       = {sr_q, byte_in};
        word_valid_d = 1'b1;
      end
    end
  end

  assign lane       = lane_q;
  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for InstructionMem: holds mips_32 in reset, writes
// the image word by word, and releases the core only when the XOR checksum matches.
module imem_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  ld_state_e         state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  index_q, index_d;
  logic [7:0]        csum_q, csum_d;

  logic              accept_c;
  logic [LEN_W-1:0]  hdr_len_c;
  logic              pk_accept_c;
  logic              pk_clear_c;
  logic [LANE_W-1:0] pk_lane;
  logic              pk_word_valid;
  logic [WORD_W-1:0] pk_word;

  assign accept_c  = in_valid & in_ready_q;
  assign hdr_len_c = {len_hi_q, in_data};

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .accept     (pk_accept_c),
    .clear      (pk_clear_c),
    .byte_in    (in_data),
    .lane       (pk_lane),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      len_hi_q    <= '0;
      count_q     <= '0;
      index_q     <= '0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_addr_q  <= mem_addr_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      len_hi_q    <= len_hi_d;
      count_q     <= count_d;
      index_q     <= index_d;
      csum_q      <= csum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    len_hi_d    = len_hi_q;
    count_d     = count_q;
    index_d     = index_q;
    csum_d      = csum_q;
    pk_accept_c = 1'b0;
    pk_clear_c  = 1'b0;

    unique case (state_q)
      IDLE: state_d = LEN_HI;

      LEN_HI: begin
        if (accept_c) begin
          len_hi_d = in_data;
          state_d  = LEN_LO;
        end
      end

      LEN_LO: begin
        if (accept_c) begin
          count_d = hdr_len_c;
          if (32'(hdr_len_c) > MAX_WORDS) begin
            state_d = ERR;
          end else if (hdr_len_c == '0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
      end

      // Address is captured with the last lane so it lines up with word_valid.
      DATA: begin
        if (accept_c) begin
          pk_accept_c = 1'b1;
          csum_d      = csum_q ^ in_data;
          if (pk_lane == LANE_W'(WORD_BYTES - 1)) begin
            mem_addr_d = BASE_ADDR + 32'({index_q, 2'b00});
            index_d    = index_q + LEN_W'(1);
            if (index_q == count_q - LEN_W'(1)) begin
              state_d = CHECK;
            end
          end
        end
      end

      CHECK: begin
        if (accept_c) begin
          state_d = (in_data == csum_q) ? RUN : ERR;
        end
      end

      RUN, ERR: begin
        if (start) begin
          state_d    = LEN_HI;
          len_hi_d   = '0;
          count_d    = '0;
          index_d    = '0;
          csum_d     = '0;
          pk_clear_c = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Status outputs are decoded from the next state so they flip on the entering edge.
    in_ready_d  = is_load_state(state_d);
    cpu_reset_d = (state_d != RUN);
    done_d      = (state_d == RUN);
    error_d     = (state_d == ERR);
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = pk_word_valid;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = pk_word;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
